// File: rtl/vic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vic_pkg
//  Purpose  : Shared encodings for the nested vectored interrupt controller:
//             trigger modes, the global-enable register address and the
//             bit offsets of the per-line configuration word.
//  Revision : 1.0  initial release
// ============================================================================
package vic_pkg;

    // Trigger modes held in cfg[1:0]
    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;
    localparam logic [1:0] MODE_LOW  = 2'b11;

    // Register address of the global enable bit
    localparam logic [5:0] GLOBAL_EN_ADDR = 6'd63;

    // Line cfg word = {en, prio[PRIO_W-1:0], mode[1:0]}; en sits at PRIO_W+2
    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_PRIO_LSB = 2;

    // Level modes have bit 1 set; edge modes have it clear
    function automatic logic is_level_mode(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage : vic_pkg
`default_nettype wire

// File: rtl/vic_irq_line.sv
`default_nettype none
// ============================================================================
//  Module   : vic_irq_line
//  Purpose  : Request detector for one interrupt line. Keeps the previous
//             sample for edge detection and a sticky pending bit for the
//             edge modes; level modes report the live level instead.
//  Revision : 1.0  initial release
// ============================================================================
module vic_irq_line
    import vic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       pend_o
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic edge_w;
    logic level_w;

    // Edge/level detection and next pending value. The edge seen this cycle
    // is visible immediately so a fresh edge can be taken on the same clock.
    always_comb begin
        edge_w  = 1'b0;
        level_w = 1'b0;
        case (mode_i)
            MODE_RISE: edge_w  = ext_i & ~prev_q;
            MODE_FALL: edge_w  = ~ext_i & prev_q;
            MODE_HIGH: level_w = ext_i;
            default:   level_w = ~ext_i;
        endcase
        pend_o = is_level_mode(mode_i) ? level_w : (pend_q | edge_w);
        pend_d = (clr_i || is_level_mode(mode_i)) ? 1'b0 : (pend_q | edge_w);
    end

    // Previous-sample and latched-edge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= ext_i;
            pend_q <= pend_d;
        end
    end

endmodule : vic_irq_line
`default_nettype wire

// File: rtl/vic_nested.sv
`default_nettype none
// ============================================================================
//  Module   : vic_nested
//  Purpose  : Nested vectored interrupt controller. Per-line trigger mode,
//             enable and priority; a save stack of {PC, CCodes, level} lets
//             a more urgent request preempt a running handler; reti pops.
//  Revision : 1.0  initial release
// ============================================================================
module vic_nested
    import vic_pkg::*;
#(
    parameter int          NUM_IRQ    = 31,
    parameter int          PC_W       = 32,
    parameter int          CC_W       = 4,
    parameter int          PRIO_W     = 2,
    parameter int          NEST_DEPTH = 4,
    parameter int unsigned VEC_BASE   = 32'h100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PC_W-1:0]                   i_PC,
    input  logic [CC_W-1:0]                   i_CCodes,
    input  logic [5:0]                        i_VIC_regaddr,
    input  logic [PRIO_W+2:0]                 i_VIC_data,
    input  logic                              i_VIC_we,
    input  logic [NUM_IRQ-1:0]                i_ext,
    input  logic                              i_reti,
    input  logic                              i_NOT_FLUSH,
    output logic [PRIO_W+2:0]                 o_VIC_data,
    output logic [PC_W-1:0]                   o_VIC_iaddr,
    output logic                              o_VIC_ctrl,
    output logic [CC_W-1:0]                   o_CCodes,
    output logic                              o_cc_we,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   o_nest_level,
    output logic                              o_err
);

    localparam int DW      = PRIO_W + 3;
    localparam int LVL_W   = PRIO_W + 1;
    localparam int EN_BIT  = PRIO_W + 2;
    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
    localparam int IDX_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] c_MAX_DEPTH = DEPTH_W'(NEST_DEPTH);

    logic [DW-1:0]      cfg_q [NUM_IRQ];
    logic               gen_q;
    logic [LVL_W-1:0]   cur_level_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [PC_W-1:0]    pc_stk_q  [NEST_DEPTH];
    logic [CC_W-1:0]    cc_stk_q  [NEST_DEPTH];
    logic [LVL_W-1:0]   lvl_stk_q [NEST_DEPTH];

    logic [NUM_IRQ-1:0] pend_w;
    logic [NUM_IRQ-1:0] elig_w;
    logic               found_w;
    logic [5:0]         win_idx_w;
    logic [PRIO_W-1:0]  win_prio_w;
    logic               take_w;
    logic               pop_w;
    logic [IDX_W-1:0]   push_idx_w;
    logic [IDX_W-1:0]   pop_idx_w;
    logic [PC_W-1:0]    vec_w;

    // One detector per line; pending clears on a cfg write to the line or
    // when the line wins a take.
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        logic [PRIO_W-1:0] prio_w;
        logic              clr_w;
        assign prio_w    = cfg_q[g][CFG_PRIO_LSB +: PRIO_W];
        assign clr_w     = (i_VIC_we && (i_VIC_regaddr == 6'(g)))
                         || (take_w && (win_idx_w == 6'(g)));
        assign elig_w[g] = cfg_q[g][EN_BIT] && pend_w[g]
                         && (({1'b0, prio_w} + LVL_W'(1)) > cur_level_q);
        vic_irq_line u_line (
            .clk    (clk),
            .rst    (rst),
            .ext_i  (i_ext[g]),
            .mode_i (cfg_q[g][CFG_MODE_LSB +: 2]),
            .clr_i  (clr_w),
            .pend_o (pend_w[g])
        );
    end

    // Priority arbiter: highest prio wins, scanning downward so ties keep the lowest index
    always_comb begin
        found_w    = 1'b0;
        win_idx_w  = 6'd0;
        win_prio_w = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig_w[i] && (!found_w || (cfg_q[i][CFG_PRIO_LSB +: PRIO_W] >= win_prio_w))) begin
                found_w    = 1'b1;
                win_idx_w  = 6'(i);
                win_prio_w = cfg_q[i][CFG_PRIO_LSB +: PRIO_W];
            end
        end
    end

    assign pop_w      = i_reti && (depth_q != '0);
    assign take_w     = gen_q && found_w && i_NOT_FLUSH && !i_reti && (depth_q < c_MAX_DEPTH);
    assign push_idx_w = IDX_W'(depth_q);
    assign pop_idx_w  = IDX_W'(depth_q - DEPTH_W'(1));
    assign vec_w      = PC_W'(VEC_BASE + (32'(win_idx_w) * VEC_STRIDE));

    // Configuration registers; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_q <= 1'b0;
            for (int i = 0; i < NUM_IRQ; i++) cfg_q[i] <= '0;
        end else if (i_VIC_we) begin
            if (i_VIC_regaddr == GLOBAL_EN_ADDR) gen_q <= i_VIC_data[0];
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (i_VIC_regaddr == 6'(i)) cfg_q[i] <= i_VIC_data;
            end
        end
    end

    // Register readback of the addressed location
    always_comb begin
        o_VIC_data = '0;
        if (i_VIC_regaddr == GLOBAL_EN_ADDR) o_VIC_data = DW'(gen_q);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_VIC_regaddr == 6'(i)) o_VIC_data = cfg_q[i];
        end
    end

    // Save stack and current service level; reti has precedence over a take
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= '0;
            cur_level_q <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                pc_stk_q[i]  <= '0;
                cc_stk_q[i]  <= '0;
                lvl_stk_q[i] <= '0;
            end
        end else if (pop_w) begin
            depth_q     <= depth_q - DEPTH_W'(1);
            cur_level_q <= lvl_stk_q[pop_idx_w];
        end else if (take_w) begin
            pc_stk_q[push_idx_w]  <= i_PC;
            cc_stk_q[push_idx_w]  <= i_CCodes;
            lvl_stk_q[push_idx_w] <= cur_level_q;
            depth_q               <= depth_q + DEPTH_W'(1);
            cur_level_q           <= {1'b0, win_prio_w} + LVL_W'(1);
        end
    end

    // Registered redirect outputs: single-cycle strobes plus sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            o_VIC_ctrl  <= 1'b0;
            o_VIC_iaddr <= '0;
            o_cc_we     <= 1'b0;
            o_CCodes    <= '0;
            o_err       <= 1'b0;
        end else begin
            o_VIC_ctrl <= 1'b0;
            o_cc_we    <= 1'b0;
            if (pop_w) begin
                o_VIC_ctrl  <= 1'b1;
                o_cc_we     <= 1'b1;
                o_VIC_iaddr <= pc_stk_q[pop_idx_w];
                o_CCodes    <= cc_stk_q[pop_idx_w];
            end else if (take_w) begin
                o_VIC_ctrl  <= 1'b1;
                o_VIC_iaddr <= vec_w;
            end
            if (i_reti && (depth_q == '0)) o_err <= 1'b1;
        end
    end

    assign o_nest_level = depth_q;

endmodule : vic_nested
`default_nettype wire
